ldm_stm_sequencer: RTL and testbench

- Multi-cycle initiator that drives the register-file ports and data memory for ARM LDM/STM block transfers.
- Walks a 16-bit register list, lowest register first, one register per cycle.
  - STM: reads the register file and writes memory.
  - LDM: reads memory and writes the register file, with R15 redirected to a PC write port.
- Sits beside the datapath. Asserts busy so the control unit holds the PC and suppresses its own register-file and memory enables.

---
 rtl/lsm_pkg.sv | 21 ++
 rtl/ldm_stm_sequencer_if.sv | 35 +++
 rtl/prio_enc16.sv | 13 +
 rtl/ldm_stm_sequencer.sv | 119 +++++++++++
 tb/tb_ldm_stm_sequencer.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/lsm_pkg.sv
// Shared types and helpers for the LDM/STM block-transfer sequencer.
package lsm_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_XFER = 2'd1,
        S_WB   = 2'd2,
        S_DONE = 2'd3
    } state_e;

    localparam int         WORD_BYTES = 4;
    localparam logic [3:0] PC_IDX     = 4'd15;

    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] c;
        c = '0;
        for (int i = 0; i < 16; i++) c = c + {4'd0, v[i]};
        return c;
    endfunction

endpackage

// File: rtl/ldm_stm_sequencer_if.sv
// Control, register-file and memory signals of the LDM/STM sequencer.
// master = sequencer side, slave = datapath/control/memory side.
interface ldm_stm_sequencer_if #(parameter int XLEN = 32);
    logic            start;
    logic            is_load;
    logic            pre;
    logic            up;
    logic            wback;
    logic [3:0]      base_reg;
    logic [XLEN-1:0] base_val;
    logic [15:0]     reglist;
    logic            busy;
    logic            done;
    logic [3:0]      rf_ra;
    logic [XLEN-1:0] rf_rd;
    logic [3:0]      rf_wa;
    logic            rf_we;
    logic [XLEN-1:0] rf_wd;
    logic            pc_we;
    logic [XLEN-1:0] pc_wd;
    logic [XLEN-1:0] mem_addr;
    logic            mem_we;
    logic [XLEN-1:0] mem_wd;
    logic [XLEN-1:0] mem_rd;

    modport master (
        input  start, is_load, pre, up, wback, base_reg, base_val, reglist, rf_rd, mem_rd,
        output busy, done, rf_ra, rf_wa, rf_we, rf_wd, pc_we, pc_wd, mem_addr, mem_we, mem_wd
    );

    modport slave (
        output start, is_load, pre, up, wback, base_reg, base_val, reglist, rf_rd, mem_rd,
        input  busy, done, rf_ra, rf_wa, rf_we, rf_wd, pc_we, pc_wd, mem_addr, mem_we, mem_wd
    );
endinterface

// File: rtl/prio_enc16.sv
// Lowest-set-bit encoder for the remaining register list.
module prio_enc16 (
    input  logic [15:0] list,
    output logic [3:0]  idx,
    output logic        valid
);
    always_comb begin
        idx   = 4'd0;
        valid = |list;
        for (int i = 15; i >= 0; i--)
            if (list[i]) idx = i[3:0];
    end
endmodule

// File: rtl/ldm_stm_sequencer.sv
// LDM/STM block-transfer sequencer: one register per cycle, lowest first.
// Optional macro LSM_EMPTY_R15_EN: empty list transfers R15 with a 0x40 offset.
module ldm_stm_sequencer
    import lsm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    ldm_stm_sequencer_if.master  bus
);
    state_e            state_q;
    logic [15:0]       list_q, list_d;
    logic [XLEN-1:0]   addr_q, final_q;
    logic [3:0]        base_reg_q;
    logic              is_load_q, wb_q;

    logic [3:0]        idx;
    logic              idx_vld;

    logic [15:0]       list_s;
    logic [4:0]        n_s;
    logic [XLEN-1:0]   off_s, addr_s, final_s;
    logic              wb_s;

    prio_enc16 u_enc (.list(list_q), .idx(idx), .valid(idx_vld));

    // Operand decode used only on the IDLE->busy edge
    always_comb begin
        list_s = bus.reglist;
        n_s    = popcount16(bus.reglist);
`ifdef LSM_EMPTY_R15_EN
        if (n_s == 5'd0) begin
            list_s = 16'h8000;
            n_s    = 5'd16;
        end
`endif
        off_s = XLEN'(n_s) * XLEN'(WORD_BYTES);
        if (bus.up)
            addr_s = bus.pre ? bus.base_val + XLEN'(WORD_BYTES) : bus.base_val;
        else
            addr_s = bus.pre ? bus.base_val - off_s
                             : bus.base_val - off_s + XLEN'(WORD_BYTES);
        final_s = bus.up ? bus.base_val + off_s : bus.base_val - off_s;
        // A loaded base value beats writeback; PC as base never writes back
        wb_s = bus.wback && (bus.base_reg != PC_IDX) &&
               !(bus.is_load && list_s[bus.base_reg]);
    end

    assign list_d = list_q & ~(16'h0001 << idx);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            list_q     <= '0;
            addr_q     <= '0;
            final_q    <= '0;
            base_reg_q <= '0;
            is_load_q  <= 1'b0;
            wb_q       <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (bus.start) begin
                    list_q     <= list_s;
                    addr_q     <= addr_s;
                    final_q    <= final_s;
                    base_reg_q <= bus.base_reg;
                    is_load_q  <= bus.is_load;
                    wb_q       <= wb_s;
                    state_q    <= (n_s != 5'd0) ? S_XFER : S_DONE;
                end
                S_XFER: begin
                    list_q <= list_d;
                    addr_q <= addr_q + XLEN'(WORD_BYTES);
                    if (list_d == 16'h0000)
                        state_q <= wb_q ? S_WB : S_DONE;
                end
                S_WB:    state_q <= S_DONE;
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Outputs decode from registered state; data paths pass through
    always_comb begin
        bus.busy     = (state_q == S_XFER) || (state_q == S_WB);
        bus.done     = (state_q == S_DONE);
        bus.rf_ra    = '0;
        bus.rf_wa    = '0;
        bus.rf_we    = 1'b0;
        bus.rf_wd    = '0;
        bus.pc_we    = 1'b0;
        bus.pc_wd    = '0;
        bus.mem_addr = '0;
        bus.mem_we   = 1'b0;
        bus.mem_wd   = '0;
        if (state_q == S_XFER && idx_vld) begin
            bus.mem_addr = addr_q;
            if (!is_load_q) begin
                bus.rf_ra  = idx;
                bus.mem_wd = bus.rf_rd;
                bus.mem_we = 1'b1;
            end else if (idx == PC_IDX) begin
                bus.pc_wd = bus.mem_rd & ~XLEN'(3);
                bus.pc_we = 1'b1;
            end else begin
                bus.rf_wa = idx;
                bus.rf_wd = bus.mem_rd;
                bus.rf_we = 1'b1;
            end
        end else if (state_q == S_WB) begin
            bus.rf_wa = base_reg_q;
            bus.rf_wd = final_q;
            bus.rf_we = 1'b1;
        end
    end

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Directed table-driven bench for ldm_stm_sequencer (default or LSM_EMPTY_R15_EN build).
module tb_ldm_stm_sequencer;
    logic clk;
    logic reset;
    int   checks;
    int   failures;

    ldm_stm_sequencer_if #(.XLEN(32)) bus ();

    ldm_stm_sequencer #(.XLEN(32)) dut (.clk(clk), .reset(reset), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file returns a tagged value; R15 reads as PC+8
    always_comb bus.rf_rd  = (bus.rf_ra == 4'hF) ? 32'h0000_1008 : {28'hA00_0000, bus.rf_ra};
    always_comb bus.mem_rd = (bus.mem_addr == 32'h1FC) ? 32'h0000_3007 : 32'h5500_0000 + bus.mem_addr;

    typedef struct {
        string            name;
        logic             is_load, pre, up, wback;
        logic [3:0]       base_reg;
        logic [31:0]      base;
        logic [15:0]      reglist;
        int               n;
        logic [31:0]      addr0;
        logic [3:0][3:0]  idx;
        logic [31:0]      pc;
        logic             wb;
        logic [31:0]      fin;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic chk_quiet(input string name);
        chk({name, "_en"}, 32'({bus.busy, bus.done, bus.rf_we, bus.pc_we, bus.mem_we}), 32'd0);
        chk({name, "_data"}, bus.mem_addr | bus.mem_wd | bus.rf_wd | bus.pc_wd, 32'd0);
        chk({name, "_idx"}, 32'({bus.rf_wa, bus.rf_ra}), 32'd0);
    endtask

    task automatic drive_start(input vec_t v);
        bus.is_load  = v.is_load;
        bus.pre      = v.pre;
        bus.up       = v.up;
        bus.wback    = v.wback;
        bus.base_reg = v.base_reg;
        bus.base_val = v.base;
        bus.reglist  = v.reglist;
        bus.start    = 1'b1;
    endtask

    task automatic run_vec(input vec_t v);
        logic [31:0] a;
        logic [3:0]  ix;
        @(negedge clk);
        drive_start(v);
        @(negedge clk);
        bus.start = 1'b0;
        for (int k = 0; k < v.n; k++) begin
            a  = v.addr0 + 32'(4 * k);
            ix = v.idx[k];
            chk($sformatf("%s_busy%0d", v.name, k), 32'(bus.busy), 32'd1);
            chk($sformatf("%s_addr%0d", v.name, k), bus.mem_addr, a);
            if (!v.is_load) begin
                chk($sformatf("%s_mwe%0d", v.name, k), 32'({bus.mem_we, bus.rf_we, bus.pc_we}), 32'b100);
                chk($sformatf("%s_ra%0d", v.name, k), 32'(bus.rf_ra), 32'(ix));
                chk($sformatf("%s_mwd%0d", v.name, k), bus.mem_wd,
                    (ix == 4'hF) ? 32'h0000_1008 : {28'hA00_0000, ix});
            end else if (ix != 4'hF) begin
                chk($sformatf("%s_rwe%0d", v.name, k), 32'({bus.mem_we, bus.rf_we, bus.pc_we}), 32'b010);
                chk($sformatf("%s_wa%0d", v.name, k), 32'(bus.rf_wa), 32'(ix));
                chk($sformatf("%s_rwd%0d", v.name, k), bus.rf_wd, 32'h5500_0000 + a);
            end else begin
                chk($sformatf("%s_pwe%0d", v.name, k), 32'({bus.mem_we, bus.rf_we, bus.pc_we}), 32'b001);
                chk($sformatf("%s_pwd%0d", v.name, k), bus.pc_wd, v.pc);
            end
            @(negedge clk);
        end
        if (v.wb) begin
            chk({v.name, "_wb_en"}, 32'({bus.busy, bus.rf_we, bus.mem_we, bus.pc_we}), 32'b1100);
            chk({v.name, "_wb_wa"}, 32'(bus.rf_wa), 32'(v.base_reg));
            chk({v.name, "_wb_wd"}, bus.rf_wd, v.fin);
            @(negedge clk);
        end
        chk({v.name, "_done"}, 32'({bus.done, bus.busy, bus.rf_we, bus.mem_we, bus.pc_we}), 32'b10000);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk_quiet({v.name, "_after"});
    endtask

    function automatic vec_t mk(input string name, input logic ld, input logic p, input logic u,
                                input logic w, input logic [3:0] br, input logic [31:0] base,
                                input logic [15:0] rl, input int n, input logic [31:0] a0,
                                input logic [15:0] ixs, input logic [31:0] pc, input logic wb,
                                input logic [31:0] fin);
        vec_t v;
        v.name = name; v.is_load = ld; v.pre = p; v.up = u; v.wback = w;
        v.base_reg = br; v.base = base; v.reglist = rl; v.n = n; v.addr0 = a0;
        v.idx = ixs; v.pc = pc; v.wb = wb; v.fin = fin;
        return v;
    endfunction

    vec_t vecs [7];
    vec_t vr;

    initial begin
        checks = 0;
        failures = 0;
        bus.start = 1'b0; bus.is_load = 1'b0; bus.pre = 1'b0; bus.up = 1'b0;
        bus.wback = 1'b0; bus.base_reg = '0; bus.base_val = '0; bus.reglist = '0;

        //          name     ld p  u  w  br     base          list      n  addr0         idx       pc            wb fin
        vecs[0] = mk("stmia", 0, 0, 1, 1, 4'd13, 32'h100,      16'h0016, 3, 32'h100,      16'h0421, 32'h0,        1, 32'h10C);
        vecs[1] = mk("ldmdb", 1, 1, 0, 0, 4'd13, 32'h200,      16'h8003, 3, 32'h1F4,      16'h0F10, 32'h3004,     0, 32'h0);
        vecs[2] = mk("ldmib", 1, 1, 1, 1, 4'd2,  32'h300,      16'h0004, 1, 32'h304,      16'h0002, 32'h0,        0, 32'h0);
        vecs[3] = mk("stmda", 0, 0, 0, 1, 4'd3,  32'h0,        16'h0001, 1, 32'h0,        16'h0000, 32'h0,        1, 32'hFFFF_FFFC);
`ifdef LSM_EMPTY_R15_EN
        vecs[4] = mk("empty", 0, 0, 1, 1, 4'd5,  32'h1000,     16'h0000, 1, 32'h1000,     16'h000F, 32'h0,        1, 32'h1040);
`else
        vecs[4] = mk("empty", 0, 0, 1, 1, 4'd5,  32'h1000,     16'h0000, 0, 32'h0,        16'h0000, 32'h0,        0, 32'h0);
`endif
        vecs[5] = mk("pcbase", 0, 0, 1, 1, 4'd15, 32'h40,      16'h0003, 2, 32'h40,       16'h0010, 32'h0,        0, 32'h0);
        vecs[6] = mk("stmbin", 0, 1, 0, 1, 4'd5,  32'h80,      16'h0021, 2, 32'h78,       16'h0050, 32'h0,        1, 32'h78);

        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk_quiet("reset");

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Reset during the 2nd XFER cycle of a 4-register LDM
        vr = mk("ldmrst", 1, 0, 1, 1, 4'd13, 32'h400, 16'h00F0, 4, 32'h400, 16'h7654, 32'h0, 1, 32'h410);
        @(negedge clk);
        drive_start(vr);
        @(negedge clk);
        bus.start = 1'b0;
        chk("rst_x1_wa", 32'({bus.rf_we, bus.rf_wa}), 32'h14);
        @(negedge clk);
        chk("rst_x2_addr", bus.mem_addr, 32'h404);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk_quiet("rst_idle");
        @(negedge clk);
        chk_quiet("rst_nowb");
        run_vec(vecs[2]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
